// File: rtl/pi_txn_queue.sv
// Pi register-port transaction capture and queue feeding the 68000 bus-cycle sequencer.
// Optional PI_TXN_WRITE_POSTING_EN: busy only for pending reads or a full queue.
module pi_txn_queue #(
  parameter int DEPTH = 4
) (
  input  logic        c200m,
  input  logic        reset,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] pi_d_in,
  output logic [15:0] pi_d_out,
  output logic        pi_d_oe,
  output logic        PI_TXN_IN_PROGRESS,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [23:0] op_addr,
  output logic [15:0] op_data,
  output logic        op_rw,
  output logic        op_uds_n,
  output logic        op_lds_n,
  output logic [2:0]  op_fc,
  input  logic        op_done,
  input  logic [15:0] op_rdata,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_STATUS  = 2'd3
  } reg_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } entry_t;

  logic          wr_s1, wr_s2, wr_s3;
  logic          rd_s1, rd_s2;
  logic          unused_rd;
  logic [15:0]   data_q;
  logic [15:0]   addr_q;
  logic [15:0]   rd_data_q;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [7:0]    outstanding, outstanding_n;
  logic [7:0]    rd_pend, rd_pend_n;
  logic          last_rw;
  logic          busy_q, busy_n;
  logic          overflow_q;

  logic          wr_event, commit, status_clr, full, pop, push, done_ok, rd_done;
  reg_t          sel;
  entry_t        new_entry, head;

  assign sel        = reg_t'(PI_A);
  assign wr_event   = wr_s2 && !wr_s3;
  assign commit     = wr_event && (sel == REG_ADDR_HI);
  assign status_clr = wr_event && (sel == REG_STATUS) && pi_d_in[14];
  assign full       = (count == CW'(DEPTH));
  assign op_valid   = (count != '0);
  assign pop        = op_valid && op_ready;
  assign push       = commit && (!full || pop);
  assign done_ok    = op_done && (outstanding != '0);
  assign rd_done    = done_ok && last_rw;
  // The synchronised read strobe is kept for the read-side path; the Pi
  // drive enable deliberately follows the raw strobe.
  assign unused_rd  = rd_s2;

  always_comb begin
    new_entry.addr  = {pi_d_in[7:0], addr_q};
    new_entry.data  = data_q;
    new_entry.rw    = pi_d_in[9];
    new_entry.uds_n = pi_d_in[8] ? addr_q[0] : 1'b0;
    new_entry.lds_n = pi_d_in[8] ? !addr_q[0] : 1'b0;
    new_entry.fc    = pi_d_in[15:13];
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_n       = count;
    outstanding_n = outstanding;
    rd_pend_n     = rd_pend;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
    if (pop && !done_ok)      outstanding_n = outstanding + 8'd1;
    else if (done_ok && !pop) outstanding_n = outstanding - 8'd1;
    if (push && new_entry.rw && !(rd_done && rd_pend != '0)) rd_pend_n = rd_pend + 8'd1;
    else if (!(push && new_entry.rw) && rd_done && rd_pend != '0) rd_pend_n = rd_pend - 8'd1;
`ifdef PI_TXN_WRITE_POSTING_EN
    busy_n = (rd_pend_n != '0) || (count_n == CW'(DEPTH));
`else
    busy_n = (count_n != '0) || (outstanding_n != '0);
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge c200m) begin
    if (reset) begin
      // Edge-detect history preset high: a strobe still high when reset
      // releases must fall and rise again before it counts as a write.
      wr_s1       <= 1'b1;
      wr_s2       <= 1'b1;
      wr_s3       <= 1'b1;
      rd_s1       <= 1'b0;
      rd_s2       <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      rd_data_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      rd_pend     <= '0;
      last_rw     <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_s1       <= PI_WR;
      wr_s2       <= wr_s1;
      wr_s3       <= wr_s2;
      rd_s1       <= PI_RD;
      rd_s2       <= rd_s1;
      if (wr_event && sel == REG_DATA)    data_q <= pi_d_in;
      if (wr_event && sel == REG_ADDR_LO) addr_q <= pi_d_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_rw <= head.rw;
      end
      if (rd_done) rd_data_q <= op_rdata;
      count       <= count_n;
      outstanding <= outstanding_n;
      rd_pend     <= rd_pend_n;
      busy_q      <= busy_n;
      if (commit && !push) overflow_q <= 1'b1;
      else if (status_clr) overflow_q <= 1'b0;
    end
  end

  // NOTE: the entry storage has no reset; the empty queue presents idle values instead.
  always_ff @(posedge c200m) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head               = mem[rd_ptr];
  assign op_addr            = op_valid ? head.addr  : 24'h0;
  assign op_data            = op_valid ? head.data  : 16'h0;
  assign op_rw              = op_valid ? head.rw    : 1'b1;
  assign op_uds_n           = op_valid ? head.uds_n : 1'b1;
  assign op_lds_n           = op_valid ? head.lds_n : 1'b1;
  assign op_fc              = op_valid ? head.fc    : 3'b111;
  assign pi_d_out           = rd_data_q;
  assign pi_d_oe            = PI_RD && (PI_A == 2'd0);
  assign PI_TXN_IN_PROGRESS = busy_q;
  assign overflow           = overflow_q;

endmodule
